ioctl_upload_tx: RTL

//  SPI-slave transmitter for the upload direction of the ioctl channel: core RAM -> ARM.

---
 rtl/ioctl_pkg.sv | 16 +
 rtl/spi_edge_sync.sv | 45 ++++
 rtl/ioctl_upload_tx.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ioctl_pkg.sv
// Shared constants and types for the ioctl SPI channel (download and upload paths).
package ioctl_pkg;

   localparam logic [7:0] CMD_UPLOAD      = 8'h58;
   localparam logic [7:0] CMD_FILE_TX     = 8'h53;
   localparam logic [7:0] CMD_FILE_TX_DAT = 8'h54;
   localparam logic [7:0] CMD_FILE_INDEX  = 8'h55;

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      XFER,
      IGNORE
   } ioctl_tx_state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into clk_sys and flags SCK edges.
// A pin change acts on logic three clk_sys edges later.
module spi_edge_sync (
   input  logic clk_sys,
   input  logic reset,
   input  logic i_sck,
   input  logic i_ss,
   input  logic i_di,
   output logic o_ss,
   output logic o_di,
   output logic o_sck_rise,
   output logic o_sck_fall
);

   logic r_sck_meta, r_sck_sync, r_sck_prev;
   logic r_ss_meta, r_ss_sync;
   logic r_di_meta, r_di_sync;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_sck_meta <= 1'b0;
         r_sck_sync <= 1'b0;
         r_sck_prev <= 1'b0;
         // Deselected after reset so the FSM parks in IDLE.
         r_ss_meta  <= 1'b1;
         r_ss_sync  <= 1'b1;
         r_di_meta  <= 1'b0;
         r_di_sync  <= 1'b0;
      end else begin
         r_sck_meta <= i_sck;
         r_sck_sync <= r_sck_meta;
         r_sck_prev <= r_sck_sync;
         r_ss_meta  <= i_ss;
         r_ss_sync  <= r_ss_meta;
         r_di_meta  <= i_di;
         r_di_sync  <= r_di_meta;
      end
   end

   assign o_ss       = r_ss_sync;
   assign o_di       = r_di_sync;
   assign o_sck_rise = r_sck_sync & ~r_sck_prev;
   assign o_sck_fall = ~r_sck_sync & r_sck_prev;

endmodule

// File: rtl/ioctl_upload_tx.sv
// SPI-slave upload transmitter: after CMD_UPLOAD, streams core RAM bytes MSB-first on SPI_DO
// (mode 0), prefetching each byte through ioctl_rd/ioctl_addr/ioctl_din.
module ioctl_upload_tx #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned UPLOAD_LEN = 1024,
   parameter logic [7:0]  CMD_UPLOAD = ioctl_pkg::CMD_UPLOAD
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              SPI_SCK,
   input  logic              SPI_SS,
   input  logic              SPI_DI,
   output logic              SPI_DO,
   output logic              spi_do_en,
   output logic              ioctl_upload,
   output logic              ioctl_rd,
   output logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_din,
   input  logic              upload_req,
   output logic              upload_pending
);

   import ioctl_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(UPLOAD_LEN - 1);

   logic w_ss, w_di, w_sck_rise, w_sck_fall;
   logic [7:0] w_cmd_byte;
   logic w_cmd_done, w_accept, w_load, w_shift;

   ioctl_tx_state_t r_state, w_state_next;

   logic [2:0]        r_bitcnt;
   logic [6:0]        r_cmd;
   logic [7:0]        r_shreg;
   logic [7:0]        r_hold;
   logic              r_rd;
   logic              r_rd_q;
   logic              r_eob;
   logic [ADDR_W-1:0] r_addr;
   logic              r_upload;
   logic              r_do_en;
   logic              r_pending;

   spi_edge_sync u_sync (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .i_sck      (SPI_SCK),
      .i_ss       (SPI_SS),
      .i_di       (SPI_DI),
      .o_ss       (w_ss),
      .o_di       (w_di),
      .o_sck_rise (w_sck_rise),
      .o_sck_fall (w_sck_fall)
   );

   always_comb begin
      w_cmd_byte = {r_cmd, w_di};
      w_cmd_done = (r_state == CMD) && !w_ss && w_sck_rise && (r_bitcnt == 3'd7);
      w_accept   = w_cmd_done && (w_cmd_byte == CMD_UPLOAD);
      w_load     = (r_state == XFER) && !w_ss && w_sck_fall && (r_bitcnt == 3'd0);
      w_shift    = (r_state == XFER) && !w_ss && w_sck_fall && (r_bitcnt != 3'd0);
   end

   always_comb begin
      w_state_next = r_state;
      if (w_ss) begin
         w_state_next = IDLE;
      end else begin
         unique case (r_state)
            IDLE:   w_state_next = CMD;
            CMD:    if (w_cmd_done) w_state_next = w_accept ? XFER : IGNORE;
            XFER:   w_state_next = XFER;
            IGNORE: w_state_next = IGNORE;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_bitcnt  <= 3'd0;
         r_cmd     <= 7'd0;
         r_shreg   <= 8'd0;
         r_hold    <= 8'd0;
         r_rd      <= 1'b0;
         r_rd_q    <= 1'b0;
         r_eob     <= 1'b0;
         r_addr    <= '0;
         r_upload  <= 1'b0;
         r_do_en   <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_rd   <= 1'b0;
         r_rd_q <= r_rd;
         if (r_rd_q) r_hold <= ioctl_din;

         // A new request wins over the clear from an accepted command.
         if (upload_req)    r_pending <= 1'b1;
         else if (w_accept) r_pending <= 1'b0;

         if (w_ss) begin
            r_upload <= 1'b0;
            r_do_en  <= 1'b0;
            r_bitcnt <= 3'd0;
         end else begin
            if (r_state == IDLE) begin
               r_bitcnt <= 3'd0;
            end else if (w_sck_rise && (r_state == CMD || r_state == XFER)) begin
               r_bitcnt <= r_bitcnt + 3'd1;
            end

            if (r_state == CMD && w_sck_rise) r_cmd <= w_cmd_byte[6:0];

            if (w_accept) begin
               r_upload <= 1'b1;
               r_do_en  <= 1'b1;
               r_addr   <= '0;
               r_rd     <= 1'b1;
               r_shreg  <= 8'd0;
               r_eob    <= 1'b0;
            end

            if (w_load) begin
               if (r_eob) begin
                  r_shreg <= 8'hFF;
               end else begin
                  r_shreg <= r_hold;
                  // Last buffer byte: freeze the address and stop prefetching.
                  if (r_addr == LAST_ADDR) begin
                     r_eob <= 1'b1;
                  end else begin
                     r_addr <= r_addr + 1'b1;
                     r_rd   <= 1'b1;
                  end
               end
            end else if (w_shift) begin
               r_shreg <= {r_shreg[6:0], 1'b0};
            end
         end
      end
   end

   assign SPI_DO         = (r_state == XFER) ? r_shreg[7] : 1'b0;
   assign spi_do_en      = r_do_en;
   assign ioctl_upload   = r_upload;
   assign ioctl_rd       = r_rd;
   assign ioctl_addr     = r_addr;
   assign upload_pending = r_pending;

endmodule
